dma_mch_scheduler: RTL and testbench
====================================

Name: dma_mch_scheduler

Overview:
- Multi-channel front end for the single DMA functional engine.
- NUM_CH independent channel contexts, each with its own control bits and descriptor set, queue requests; a round-robin arbiter serialises them onto one engine.
- The block muxes the granted channel's control and descriptors into the engine, tracks per-channel busy/pending/done/error state, and aggregates IRQs.
- Sits between the per-channel CSR bank and the DMA functional wrapper. Generalises the single-channel DMA wrapper to N channels with queuing and abort.

Parameters:
- NUM_CH, 4, number of channel contexts (2..16)
- NUM_DESC, 2, descriptors per channel
- ADDR_WIDTH, 32, descriptor address and byte-count width
- BURST_WIDTH, 8, max_burst field width
- WDOG_CYCLES, 65535, watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_go_i  in  NUM_CH  per-channel start pulse
- ch_abort_i  in  NUM_CH  per-channel abort pulse
- ch_clr_i  in  NUM_CH  clear sticky done/err
- ch_max_burst_i  in  NUM_CH*BURST_WIDTH  per-channel max burst
- ch_desc_src_i  in  NUM_CH*NUM_DESC*ADDR_WIDTH  source addresses
- ch_desc_dst_i  in  NUM_CH*NUM_DESC*ADDR_WIDTH  destination addresses
- ch_desc_byt_i  in  NUM_CH*NUM_DESC*ADDR_WIDTH  byte counts
- ch_desc_en_i  in  NUM_CH*NUM_DESC  descriptor enables
- eng_go_o  out  1  engine go, level
- eng_abort_o  out  1  engine abort request
- eng_max_burst_o  out  BURST_WIDTH  snapshot of the granted channel's max burst
- eng_desc_src_o / eng_desc_dst_o / eng_desc_byt_o  out  NUM_DESC*ADDR_WIDTH  snapshot of the granted channel's descriptors
- eng_desc_en_o  out  NUM_DESC  snapshot of the granted channel's enables
- eng_done_i  in  1  engine done, level
- eng_error_i  in  1  engine error, level
- ch_pend_o  out  NUM_CH  queued
- ch_busy_o  out  NUM_CH  one-hot, granted channel
- ch_done_o  out  NUM_CH  sticky done
- ch_err_o  out  NUM_CH  sticky error
- irq_done_o  out  1  OR of ch_done_o
- irq_error_o  out  1  OR of ch_err_o

Behaviour:
- Reset: all outputs 0, FSM = IDLE, RR pointer = 0.
- Pending bits:
  - ch_go_i[k] sets pend[k] at the next edge.
  - A go to the active channel also sets pend, so the channel re-runs after completion.
  - A go to an already-pending channel has no effect.
- Abort:
  - ch_abort_i[k] on a pending channel clears pend[k].
  - On the active channel, it asserts eng_abort_o from the next cycle until the engine reports done or error.
  - Abort and go to the same channel in the same cycle: abort wins, pend stays 0.
- FSM:
  - IDLE: if any pend bit is set, grant the first set bit searching from the RR pointer upward with wrap. Latch the index, clear its pend bit, set ch_busy_o one-hot, then go to LOAD.
  - LOAD (1 cycle): register the granted channel's max_burst and descriptors into the eng_* outputs. If all of its desc_en bits are 0, set ch_done[idx] and go to RELEASE without asserting go. Otherwise go to RUN.
  - RUN: eng_go_o = 1. On eng_error_i, set ch_err[idx] and go to RELEASE. Otherwise, on eng_done_i, set ch_done[idx] and go to RELEASE. Error has priority if both are asserted.
  - RELEASE: eng_go_o = 0, eng_abort_o = 0. Wait until eng_done_i and eng_error_i are both 0. Then clear ch_busy_o, set RR pointer = idx+1 mod NUM_CH, and go to IDLE.
- Latency: ch_go_i sampled at edge 0 on an idle block gives eng_go_o = 1 after edge 3.
- Descriptor snapshot: eng_desc_* holds its value from LOAD through RELEASE. CSR changes made during a run do not affect the active transfer.
- Sticky bits: ch_clr_i[k] clears ch_done[k] and ch_err[k]. A set and a clear in the same cycle: set wins.
- IRQ outputs are registered ORs of the sticky bits.
- Reset asserted mid-run: everything returns to reset values immediately; pending requests are lost.

Optional Feature:
- Macro: DMA_MCH_WDOG_EN.
- Defined:
  - A counter of width clog2(WDOG_CYCLES+1) runs in RUN and clears on entry to RUN.
  - When it reaches WDOG_CYCLES with no done or error, the block asserts eng_abort_o, sets ch_err[idx], and goes to RELEASE.
- Undefined: there is no counter, and RUN waits on the engine indefinitely.

Test Plan:
- Single run: ch_go_i[1] pulse, desc0 en, src=0x1000, dst=0x2000, byt=64 -> eng_go_o rises 3 cycles later with those values; engine done -> ch_done_o=4'b0010, irq_done_o=1; ch_clr_i[1] -> both 0.
- Round robin: pulse ch_go_i=4'b1111 in one cycle -> grants in order 0,1,2,3. Re-pulse ch 0 and 2 while ch 3 runs -> next grants 0, then 2.
- Abort: abort the active ch 2 -> eng_abort_o=1 until eng_error_i, ch_err_o[2]=1. Abort pending ch 3 -> pend cleared, no grant.
- Empty channel: ch 0 with ch_desc_en_i=0 -> ch_done_o[0]=1, eng_go_o never asserts.
- Simultaneous events: go+abort same channel -> no pend. Clear+done same cycle -> ch_done_o stays 1. Reset mid-RUN -> all outputs 0 on the next cycle.
- DMA_MCH_WDOG_EN with WDOG_CYCLES=16 and an engine that never completes -> abort and ch_err_o set after 16 cycles in RUN.

Source files
------------

// File: rtl/dma_mch_scheduler_if.sv
// dma_mch_scheduler_if: engine-side bus between the multi-channel scheduler and the DMA engine.
// Latency: pure wiring, no storage.
// Backpressure: the engine holds done/error as levels; the scheduler keeps go high until one appears.
interface dma_mch_scheduler_if #(
  parameter int NUM_DESC    = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int BURST_WIDTH = 8
);
  logic                           go;
  logic                           abort;
  logic [BURST_WIDTH-1:0]         max_burst;
  logic [NUM_DESC*ADDR_WIDTH-1:0] desc_src;
  logic [NUM_DESC*ADDR_WIDTH-1:0] desc_dst;
  logic [NUM_DESC*ADDR_WIDTH-1:0] desc_byt;
  logic [NUM_DESC-1:0]            desc_en;
  logic                           done;
  logic                           error;

  modport master (
    output go, abort, max_burst, desc_src, desc_dst, desc_byt, desc_en,
    input  done, error
  );

  modport slave (
    input  go, abort, max_burst, desc_src, desc_dst, desc_byt, desc_en,
    output done, error
  );
endinterface

// File: rtl/dma_mch_scheduler.sv
// dma_mch_scheduler: round-robin front end serialising NUM_CH DMA channel contexts onto one engine.
// Latency: go pulse on an idle block -> eng.go high 3 edges later (pend, grant/LOAD, launch).
// Backpressure: a channel holds the engine until done/error; new requests queue as pend bits. Watchdog: DMA_MCH_WDOG_EN.
module dma_mch_scheduler #(
  parameter int NUM_CH      = 4,
  parameter int NUM_DESC    = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int BURST_WIDTH = 8,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_CH-1:0]                   ch_go_i,
  input  logic [NUM_CH-1:0]                   ch_abort_i,
  input  logic [NUM_CH-1:0]                   ch_clr_i,
  input  logic [NUM_CH*BURST_WIDTH-1:0]       ch_max_burst_i,
  input  logic [NUM_CH*NUM_DESC*ADDR_WIDTH-1:0] ch_desc_src_i,
  input  logic [NUM_CH*NUM_DESC*ADDR_WIDTH-1:0] ch_desc_dst_i,
  input  logic [NUM_CH*NUM_DESC*ADDR_WIDTH-1:0] ch_desc_byt_i,
  input  logic [NUM_CH*NUM_DESC-1:0]          ch_desc_en_i,
  dma_mch_scheduler_if.master                 eng,
  output logic [NUM_CH-1:0]                   ch_pend_o,
  output logic [NUM_CH-1:0]                   ch_busy_o,
  output logic [NUM_CH-1:0]                   ch_done_o,
  output logic [NUM_CH-1:0]                   ch_err_o,
  output logic                                irq_done_o,
  output logic                                irq_error_o
);
  localparam int IDX_W = $clog2(NUM_CH);
  localparam int DW    = NUM_DESC * ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  if (NUM_CH < 2 || NUM_CH > 16 || WDOG_CYCLES < 1) begin : g_cfg_check
    $error("dma_mch_scheduler: unsupported parameter set");
  end

  logic [1:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, rr_q, grant_idx;
  logic                   grant_vld;
  logic [NUM_CH-1:0]      cand, grant_oh;
  logic [NUM_CH-1:0]      pend_q, busy_q, done_q, err_q;
  logic [NUM_CH-1:0]      set_done, set_err, done_d, err_d;
  logic [NUM_DESC-1:0]    sel_en;
  logic                   go_q, abort_q, irq_done_q, irq_err_q;
  logic                   wdog_hit;
  logic [BURST_WIDTH-1:0] mb_q;
  logic [DW-1:0]          src_q, dst_q, byt_q;
  logic [NUM_DESC-1:0]    en_q;

  // Pick the first pending channel at or after the RR pointer; an abort in the same cycle vetoes it.
  always_comb begin
    int k;
    cand      = pend_q & ~ch_abort_i;
    grant_vld = 1'b0;
    grant_idx = '0;
    k         = 0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      k = (int'(rr_q) + i) % NUM_CH;
      if (cand[k]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
    grant_oh = (state_q == S_IDLE && grant_vld) ? (NUM_CH'(1) << grant_idx) : '0;
  end

  // Next state and sticky set requests; done/error are ignored until go has actually been presented.
  always_comb begin
    state_d  = state_q;
    set_done = '0;
    set_err  = '0;
    sel_en   = ch_desc_en_i[idx_q*NUM_DESC +: NUM_DESC];
    case (state_q)
      S_IDLE: if (grant_vld) state_d = S_LOAD;
      S_LOAD: begin
        if (sel_en == '0) begin
          set_done[idx_q] = 1'b1;
          state_d         = S_REL;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (go_q && eng.error) begin
          set_err[idx_q] = 1'b1;
          state_d        = S_REL;
        end else if (go_q && eng.done) begin
          set_done[idx_q] = 1'b1;
          state_d         = S_REL;
        end else if (wdog_hit) begin
          set_err[idx_q] = 1'b1;
          state_d        = S_REL;
        end
      end
      S_REL:   if (!eng.done && !eng.error) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign done_d = (done_q & ~ch_clr_i) | set_done;
  assign err_d  = (err_q & ~ch_clr_i) | set_err;

`ifdef DMA_MCH_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  // Count cycles spent in RUN; any other state restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wd_q <= '0;
    else if (state_q != S_RUN) wd_q <= '0;
    else if (!wdog_hit)        wd_q <= wd_q + 1'b1;
  end

  assign wdog_hit = (state_q == S_RUN) && (wd_q == WD_W'(WDOG_CYCLES));
`else
  assign wdog_hit = 1'b0;
`endif

  // FSM, granted index and round-robin pointer advance on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant_vld) idx_q <= grant_idx;
      if (state_q == S_REL && state_d == S_IDLE)
        rr_q <= (idx_q == IDX_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Per-channel status: go queues, abort and grant dequeue; sticky bits with set-over-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q     <= '0;
      busy_q     <= '0;
      done_q     <= '0;
      err_q      <= '0;
      irq_done_q <= 1'b0;
      irq_err_q  <= 1'b0;
    end else begin
      pend_q     <= (pend_q | ch_go_i) & ~ch_abort_i & ~grant_oh;
      if (state_q == S_IDLE && grant_vld)        busy_q <= grant_oh;
      else if (state_q == S_REL && state_d == S_IDLE) busy_q <= '0;
      done_q     <= done_d;
      err_q      <= err_d;
      irq_done_q <= |done_d;
      irq_err_q  <= |err_d;
    end
  end

  // Engine controls: go launches one cycle into RUN, abort latches until the channel leaves RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_q    <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      go_q    <= (state_q == S_RUN) && (state_d == S_RUN);
      abort_q <= (state_d == S_RUN) &&
                 (abort_q || (ch_abort_i[idx_q] && (state_q == S_LOAD || state_q == S_RUN)));
    end
  end

  // Snapshot the granted channel's CSRs in LOAD so later CSR writes cannot disturb the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_q  <= '0;
      src_q <= '0;
      dst_q <= '0;
      byt_q <= '0;
      en_q  <= '0;
    end else if (state_q == S_LOAD) begin
      mb_q  <= ch_max_burst_i[idx_q*BURST_WIDTH +: BURST_WIDTH];
      src_q <= ch_desc_src_i[idx_q*DW +: DW];
      dst_q <= ch_desc_dst_i[idx_q*DW +: DW];
      byt_q <= ch_desc_byt_i[idx_q*DW +: DW];
      en_q  <= sel_en;
    end
  end

  assign eng.go        = go_q;
  assign eng.abort     = abort_q | wdog_hit;
  assign eng.max_burst = mb_q;
  assign eng.desc_src  = src_q;
  assign eng.desc_dst  = dst_q;
  assign eng.desc_byt  = byt_q;
  assign eng.desc_en   = en_q;
  assign ch_pend_o     = pend_q;
  assign ch_busy_o     = busy_q;
  assign ch_done_o     = done_q;
  assign ch_err_o      = err_q;
  assign irq_done_o    = irq_done_q;
  assign irq_error_o   = irq_err_q;
endmodule

// File: tb/tb_dma_mch_scheduler.sv
// tb_dma_mch_scheduler: directed scenarios plus random traffic against a transaction-level model.
// Latency: model predicts outputs per cycle; compared on the falling edge.
// Backpressure: engine responder holds done/error levels for random durations.
module tb_dma_mch_scheduler;
  localparam int NCH = 4, ND = 2, AW = 32, BW = 8;
`ifdef DMA_MCH_WDOG_EN
  localparam int WD = 16;
`else
  localparam int WD = 65535;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]       ch_go = '0, ch_abort = '0, ch_clr = '0;
  logic [NCH*BW-1:0]    ch_mb = '0;
  logic [NCH*ND*AW-1:0] ch_src = '0, ch_dst = '0, ch_byt = '0;
  logic [NCH*ND-1:0]    ch_en = '0;
  logic [NCH-1:0]       pend, busy, done, err;
  logic                 irq_d, irq_e;
  int                   eng_mode = 1;
  logic                 man_done = 1'b0, man_err = 1'b0, auto_done = 1'b0, auto_err = 1'b0;
  int                   checks = 0, failures = 0;
  bit                   cmp_en = 1'b0;

  dma_mch_scheduler_if #(.NUM_DESC(ND), .ADDR_WIDTH(AW), .BURST_WIDTH(BW)) eng_if ();
  assign eng_if.done  = (eng_mode == 0) ? auto_done : man_done;
  assign eng_if.error = (eng_mode == 0) ? auto_err  : man_err;

  dma_mch_scheduler #(.NUM_CH(NCH), .NUM_DESC(ND), .ADDR_WIDTH(AW), .BURST_WIDTH(BW),
                      .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .ch_go_i(ch_go), .ch_abort_i(ch_abort), .ch_clr_i(ch_clr),
    .ch_max_burst_i(ch_mb), .ch_desc_src_i(ch_src), .ch_desc_dst_i(ch_dst),
    .ch_desc_byt_i(ch_byt), .ch_desc_en_i(ch_en), .eng(eng_if), .ch_pend_o(pend),
    .ch_busy_o(busy), .ch_done_o(done), .ch_err_o(err), .irq_done_o(irq_d), .irq_error_o(irq_e)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the channel holding the engine (-1 none), edges since its grant, whether it has finished.
  bit [NCH-1:0]  m_pend = '0, m_done = '0, m_err = '0;
  int            m_act = -1, m_age = 0, m_rr = 0;
  bit            m_fin = 1'b0, m_abt = 1'b0;
  logic [BW-1:0] m_mb = '0;
  logic [ND*AW-1:0] m_src = '0, m_dst = '0, m_byt = '0;
  logic [ND-1:0] m_en = '0;

  function automatic bit wd_fire();
`ifdef DMA_MCH_WDOG_EN
    return m_act >= 0 && !m_fin && m_age >= 1 && (m_age - 1) == WD;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_done = '0; m_err = '0; m_act = -1; m_age = 0; m_rr = 0;
      m_fin = 0; m_abt = 0; m_mb = '0; m_src = '0; m_dst = '0; m_byt = '0; m_en = '0;
    end else begin : step
      bit [NCH-1:0] sd, se;
      bit gvis;
      int gk;
      sd = '0; se = '0; gk = -1;
      gvis = (m_act >= 0 && !m_fin && m_age >= 2);
      if (m_act < 0) begin
        for (int i = 0; i < NCH; i++)
          if (gk < 0 && m_pend[(m_rr + i) % NCH] && !ch_abort[(m_rr + i) % NCH]) gk = (m_rr + i) % NCH;
      end else if (m_age == 0) begin
        m_mb  = ch_mb[m_act*BW +: BW];
        m_src = ch_src[m_act*ND*AW +: ND*AW];
        m_dst = ch_dst[m_act*ND*AW +: ND*AW];
        m_byt = ch_byt[m_act*ND*AW +: ND*AW];
        m_en  = ch_en[m_act*ND +: ND];
        if (m_en == '0) begin sd[m_act] = 1; m_fin = 1; end
        else m_abt = ch_abort[m_act];
        m_age = 1;
      end else if (!m_fin) begin
        if (gvis && eng_if.error)     begin se[m_act] = 1; m_fin = 1; end
        else if (gvis && eng_if.done) begin sd[m_act] = 1; m_fin = 1; end
        else if (wd_fire())           begin se[m_act] = 1; m_fin = 1; end
        m_abt = m_fin ? 1'b0 : (m_abt | ch_abort[m_act]);
        m_age++;
      end else if (!eng_if.done && !eng_if.error) begin
        m_rr  = (m_act + 1) % NCH;
        m_act = -1;
      end
      m_pend = (m_pend | ch_go) & ~ch_abort;
      if (gk >= 0) begin
        m_pend[gk] = 0; m_act = gk; m_age = 0; m_fin = 0; m_abt = 0;
      end
      m_done = (m_done & ~ch_clr) | sd;
      m_err  = (m_err & ~ch_clr) | se;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (cmp_en) begin : cmp
      bit exp_go;
      logic [NCH-1:0] exp_busy;
      exp_go   = (m_act >= 0 && !m_fin && m_age >= 2);
      exp_busy = (m_act >= 0) ? NCH'(1) << m_act : '0;
      chk("pend", pend, m_pend);
      chk("busy", busy, exp_busy);
      chk("done", done, m_done);
      chk("err", err, m_err);
      chk("irq_done", irq_d, |m_done);
      chk("irq_error", irq_e, |m_err);
      chk("eng_go", eng_if.go, exp_go);
      chk("eng_abort", eng_if.abort, m_abt | wd_fire());
      if (exp_go) begin
        chk("eng_max_burst", eng_if.max_burst, m_mb);
        chk("eng_src", eng_if.desc_src, m_src);
        chk("eng_dst", eng_if.desc_dst, m_dst);
        chk("eng_byt", eng_if.desc_byt, m_byt);
        chk("eng_en", eng_if.desc_en, m_en);
      end
    end
  end

  // Random engine: answers go after a random delay (error when aborted), drops levels randomly after go falls.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      auto_done = 0; auto_err = 0;
    end else if (eng_if.go && !auto_done && !auto_err) begin : resp
      int r;
      r = $urandom_range(0, 7);
      if (eng_if.abort || r == 0) auto_err = 1;
      else if (r < 3)             auto_done = 1;
    end else if (!eng_if.go && (auto_done || auto_err) && $urandom_range(0, 1) == 0) begin
      auto_done = 0; auto_err = 0;
    end
  end

  task automatic set_ch(input int c, input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] b, input logic [1:0] en, input logic [7:0] mb);
    ch_src[(c*ND)*AW +: AW] = s;  ch_src[(c*ND+1)*AW +: AW] = s + 32'h100;
    ch_dst[(c*ND)*AW +: AW] = d;  ch_dst[(c*ND+1)*AW +: AW] = d + 32'h100;
    ch_byt[(c*ND)*AW +: AW] = b;  ch_byt[(c*ND+1)*AW +: AW] = b + 32'h8;
    ch_en[c*ND +: ND] = en;
    ch_mb[c*BW +: BW] = mb;
  endtask

  task automatic pulse_go(input logic [NCH-1:0] v);
    ch_go = v; @(negedge clk); ch_go = '0;
  endtask

  task automatic wait_go(output int c);
    int n;
    n = 0; c = -1;
    while (!eng_if.go && n < 50) begin @(negedge clk); n++; end
    chk("wait_go_timeout", eng_if.go, 1);
    for (int i = 0; i < NCH; i++) if (busy[i]) c = i;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy != '0 && n < 20) begin @(negedge clk); n++; end
    chk("wait_idle_timeout", busy, 0);
  endtask

  task automatic finish_run(input bit e);
    if (e) man_err = 1; else man_done = 1;
    @(negedge clk);
    man_err = 0; man_done = 0;
    wait_idle();
  endtask

  task automatic do_reset();
    rst_n = 0; repeat (2) @(negedge clk); rst_n = 1; @(negedge clk);
  endtask

  initial begin
    int g[6];
    int exp_rr[6] = '{0, 1, 2, 3, 0, 2};
    int c, n;
    bit saw;
    repeat (3) @(negedge clk);
    chk("reset_state", {pend, busy, done, err, irq_d, irq_e, eng_if.go, eng_if.abort}, 0);
    rst_n = 1; cmp_en = 1;
    @(negedge clk);

    // Single run on channel 1 with hand-computed latency and snapshot values.
    set_ch(1, 32'h1000, 32'h2000, 32'd64, 2'b01, 8'd16);
    ch_go = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ch_go = '0;
      chk("go_latency_low", eng_if.go, 0);
    end
    @(negedge clk);
    chk("go_latency_high", eng_if.go, 1);
    chk("snap_src0", eng_if.desc_src[31:0], 32'h1000);
    chk("snap_dst0", eng_if.desc_dst[31:0], 32'h2000);
    chk("snap_byt0", eng_if.desc_byt[31:0], 64);
    chk("snap_en", eng_if.desc_en, 2'b01);
    chk("busy_ch1", busy, 4'b0010);
    man_done = 1; @(negedge clk);
    chk("done_ch1", done, 4'b0010);
    chk("irq_done_set", irq_d, 1);
    man_done = 0; @(negedge clk);
    chk("busy_released", busy, 0);
    ch_clr = 4'b0010; @(negedge clk); ch_clr = '0;
    chk("done_cleared", done, 0);
    chk("irq_done_cleared", irq_d, 0);

    // Round robin from pointer 0, with re-queues of 0 and 2 while 3 runs.
    do_reset();
    for (int k = 0; k < NCH; k++) set_ch(k, 32'h100 * k, 32'h8000 + k, 32'd16, 2'b01, 8'(k));
    pulse_go(4'b1111);
    for (int i = 0; i < 6; i++) begin
      wait_go(g[i]);
      if (i == 3) pulse_go(4'b0101);
      finish_run(1'b0);
    end
    for (int i = 0; i < 6; i++) chk("rr_order", g[i], exp_rr[i]);

    // Abort: pending ch 3 is dropped, active ch 2 drives eng_abort until the engine errors.
    pulse_go(4'b0100);
    wait_go(c);
    chk("abort_active_ch", c, 2);
    pulse_go(4'b1000);
    chk("pend_ch3", pend, 4'b1000);
    ch_abort = 4'b1000; @(negedge clk); ch_abort = '0;
    chk("pend_ch3_aborted", pend, 0);
    ch_abort = 4'b0100; @(negedge clk); ch_abort = '0;
    chk("eng_abort_on", eng_if.abort, 1);
    @(negedge clk);
    chk("eng_abort_held", eng_if.abort, 1);
    man_err = 1; @(negedge clk);
    chk("err_ch2", err, 4'b0100);
    chk("eng_abort_off", eng_if.abort, 0);
    man_err = 0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("no_grant_ch3", busy, 0);

    // Empty channel completes without ever asserting go.
    set_ch(0, 32'h0, 32'h0, 32'h0, 2'b00, 8'd1);
    pulse_go(4'b0001);
    saw = 0;
    repeat (8) begin @(negedge clk); saw |= eng_if.go; end
    chk("empty_done", done[0], 1);
    chk("empty_no_go", saw, 0);

    // go and abort together on an idle channel leave nothing queued.
    ch_go = 4'b0010; ch_abort = 4'b0010; @(negedge clk); ch_go = '0; ch_abort = '0;
    chk("go_abort_pend", pend, 0);
    repeat (4) @(negedge clk);
    chk("go_abort_no_grant", busy, 0);

    // Clear and done in the same cycle: the set wins.
    pulse_go(4'b0010);
    wait_go(c);
    man_done = 1; ch_clr = 4'b0010; @(negedge clk); ch_clr = '0; man_done = 0;
    chk("set_over_clear", done[1], 1);
    wait_idle();

    // Reset in the middle of a run.
    pulse_go(4'b0100);
    wait_go(c);
    @(posedge clk); #2 rst_n = 0;
    @(negedge clk);
    chk("reset_mid_run", {pend, busy, done, err, irq_d, irq_e, eng_if.go, eng_if.abort}, 0);
    rst_n = 1; @(negedge clk);

`ifdef DMA_MCH_WDOG_EN
    // Engine never answers: watchdog aborts and flags the channel.
    set_ch(1, 32'h1000, 32'h2000, 32'd64, 2'b01, 8'd16);
    pulse_go(4'b0010);
    wait_go(c);
    n = 0;
    while (!eng_if.abort && n < 40) begin @(negedge clk); n++; end
    chk("wdog_latency", n, WD - 1);
    @(negedge clk);
    chk("wdog_err", err[1], 1);
    wait_idle();
`endif

    // Random traffic with the model checking every cycle.
    eng_mode = 0;
    for (int t = 0; t < 3000; t++) begin
      ch_go    = ($urandom_range(0, 3) == 0) ? NCH'($urandom) & NCH'($urandom) : '0;
      ch_abort = ($urandom_range(0, 15) == 0) ? NCH'(1) << $urandom_range(0, NCH - 1) : '0;
      ch_clr   = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      if ($urandom_range(0, 7) == 0)
        set_ch($urandom_range(0, NCH - 1), $urandom, $urandom, $urandom,
               ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom_range(1, 3)), 8'($urandom));
      @(negedge clk);
    end
    ch_go = '0; ch_abort = '0; ch_clr = '0;
    repeat (20) @(negedge clk);
    n = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
